// File: rtl/ds_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ds_sched_pkg
// Description : Shared defaults, sample type and midscale constant for the
//               delta-sigma sample scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ds_sched_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int DIV_BITS    = 16;
    localparam int DEPTH_LOG2  = 2;

    typedef logic [SAMPLE_BITS-1:0] sample_t;

    // Offset-binary zero: the modulator sits at 50 % duty for this code.
    localparam sample_t MIDSCALE = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/ds_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ds_sample_fifo
// Description : Small synchronous sample FIFO. A push is accepted when the
//               level after this cycle's pop is below the depth, so a
//               push/pop pair on a full FIFO keeps the level unchanged.
//               A pop on an empty FIFO is ignored (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module ds_sample_fifo #(
    parameter int WIDTH      = ds_sched_pkg::SAMPLE_BITS,
    parameter int DEPTH_LOG2 = ds_sched_pkg::DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  drop_o
);
    import ds_sched_pkg::*;

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q,  level_d;
    logic                  w_pop;
    logic                  w_push;

    assign full_o  = (level_q == c_FULL);
    assign empty_o = (level_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign drop_o  = push_i & ~w_push;

    // Pointer and level next-state; pointers wrap naturally at the depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only meaningful below the level, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ds_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ds_sample_scheduler
// Description : Assembles host bytes into samples, buffers them in a FIFO and
//               releases one sample per programmable period to the
//               delta-sigma modulator, with sticky under/overflow flags.
//               Build option DS_SCHED_MUTE_ON_UNDERFLOW_EN: an empty-FIFO
//               tick loads midscale and strobes instead of holding.
// Revision    : 1.0 - initial release
// ============================================================================
module ds_sample_scheduler #(
    parameter int SAMPLE_BITS = ds_sched_pkg::SAMPLE_BITS,
    parameter int DIV_BITS    = ds_sched_pkg::DIV_BITS,
    parameter int DEPTH_LOG2  = ds_sched_pkg::DEPTH_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic [7:0]             byte_in_i,
    input  logic                   byte_we_i,
    input  logic                   byte_sync_i,
    input  logic [DIV_BITS-1:0]    rate_div_i,
    input  logic                   clr_flags_i,
    output logic [SAMPLE_BITS-1:0] sample_out_o,
    output logic                   sample_stb_o,
    output logic [DEPTH_LOG2:0]    fifo_level_o,
    output logic                   fifo_full_o,
    output logic                   underflow_o,
    output logic                   overflow_o
);
    import ds_sched_pkg::*;

    logic                   phase_q,  phase_d;
    logic [7:0]             hold_q,   hold_d;
    logic [DIV_BITS-1:0]    cnt_q,    cnt_d;
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic                   stb_q,    stb_d;
    logic                   unf_q,    unf_d;
    logic                   ovf_q,    ovf_d;

    logic                   w_phase_eff;
    logic                   w_push;
    logic [SAMPLE_BITS-1:0] w_push_data;
    logic                   w_tick;
    logic                   w_pop;
    logic [SAMPLE_BITS-1:0] w_head;
    logic                   w_empty;
    logic                   w_drop;

    // byte_sync overrides the stored phase so this cycle's byte is a low byte.
    assign w_phase_eff = byte_sync_i ? 1'b0 : phase_q;
    assign w_push      = byte_we_i & w_phase_eff;
    assign w_push_data = SAMPLE_BITS'({byte_in_i, hold_q});
    assign w_tick      = enable_i & (cnt_q == '0);
    assign w_pop       = w_tick & ~w_empty;

    ds_sample_fifo #(
        .WIDTH      (SAMPLE_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_tick),
        .data_o  (w_head),
        .level_o (fifo_level_o),
        .full_o  (fifo_full_o),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    // Next-state for byte assembly, rate counter, output sample and flags.
    always_comb begin
        phase_d  = w_phase_eff ^ byte_we_i;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        stb_d    = 1'b0;
        unf_d    = (unf_q & ~clr_flags_i) | (w_tick & w_empty);
        ovf_d    = (ovf_q & ~clr_flags_i) | w_drop;

        if (byte_we_i && !w_phase_eff) begin
            hold_d = byte_in_i;
        end

        // Paused: keep the counter primed so re-enable waits a full period.
        if (!enable_i || (cnt_q == '0)) begin
            cnt_d = rate_div_i;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        if (w_pop) begin
            sample_d = w_head;
            stb_d    = 1'b1;
        end
`ifdef DS_SCHED_MUTE_ON_UNDERFLOW_EN
        else if (w_tick) begin
            sample_d = SAMPLE_BITS'(MIDSCALE);
            stb_d    = 1'b1;
        end
`endif
    end

    // State registers; reset discards any half-assembled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            stb_q    <= 1'b0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            stb_q    <= stb_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sample_out_o = sample_q;
    assign sample_stb_o = stb_q;
    assign underflow_o  = unf_q;
    assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ds_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ds_sample_scheduler
// Description : Directed self-checking bench for ds_sample_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ds_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_we = 1'b0;
    logic        byte_sync = 1'b0;
    logic [15:0] rate_div = '0;
    logic        clr_flags = 1'b0;
    logic [15:0] sample_out;
    logic        sample_stb;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic        underflow;
    logic        overflow;

    int tests_run = 0;
    int fails = 0;

    ds_sample_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .byte_in_i    (byte_in),
        .byte_we_i    (byte_we),
        .byte_sync_i  (byte_sync),
        .rate_div_i   (rate_div),
        .clr_flags_i  (clr_flags),
        .sample_out_o (sample_out),
        .sample_stb_o (sample_stb),
        .fifo_level_o (fifo_level),
        .fifo_full_o  (fifo_full),
        .underflow_o  (underflow),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        byte_in = b;
        byte_we = 1'b1;
        step();
        byte_we = 1'b0;
    endtask

    task automatic wr_sample(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        wr_byte(t[7:0]);
        wr_byte(t[15:8]);
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (sample_out !== 16'h0000 || sample_stb !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: sample_out=%h stb=%b, want 0000/0", sample_out, sample_stb);
        end
        tests_run++;
        if (fifo_level !== 3'd0 || fifo_full !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: level=%0d full=%b unf=%b ovf=%b, want 0/0/0/0",
                     fifo_level, fifo_full, underflow, overflow);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_rate();
        int nstb;
        int unf_at;
        logic [15:0] exp_s;
        int exp_k;
        rate_div = 16'd3;
        enable   = 1'b0;
        wr_byte(8'h34);
        wr_byte(8'h12);
        wr_byte(8'h78);
        wr_byte(8'h56);
        tests_run++;
        if (fifo_level !== 3'd2) begin
            fails++;
            $display("FAIL basic_level: level=%0d, want 2", fifo_level);
        end
        enable = 1'b1;
        nstb   = 0;
        unf_at = -1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (sample_stb) begin
                exp_s = (nstb == 0) ? 16'h1234 : 16'h5678;
                exp_k = (nstb == 0) ? 4 : 8;
                tests_run++;
                if (sample_out !== exp_s || k != exp_k) begin
                    fails++;
                    $display("FAIL basic_strobe: cycle %0d sample=%h, want cycle %0d sample=%h",
                             k, sample_out, exp_k, exp_s);
                end
                nstb++;
            end
            if (underflow === 1'b1 && unf_at < 0) unf_at = k;
        end
        tests_run++;
        if (nstb != 2 || unf_at != 12) begin
            fails++;
            $display("FAIL basic_count: strobes=%0d underflow_cycle=%0d, want 2/12", nstb, unf_at);
        end
        enable = 1'b0;
        clear_flags();
    endtask

    task automatic test_overflow();
        rate_div = 16'd0;
        enable   = 1'b0;
        for (int s = 1; s <= 5; s++) wr_sample(16'(s));
        tests_run++;
        if (fifo_level !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_fill: level=%0d full=%b ovf=%b, want 4/1/1", fifo_level, fifo_full, overflow);
        end
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests_run++;
            if (sample_stb !== 1'b1 || sample_out !== 16'(k)) begin
                fails++;
                $display("FAIL ovf_order: pop %0d stb=%b sample=%h, want 1/%h", k, sample_stb, sample_out, 16'(k));
            end
        end
        step();
        tests_run++;
        if (underflow !== 1'b1 || sample_stb !== 1'b0 && sample_out !== 16'h8000 || fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL ovf_drain: unf=%b stb=%b level=%0d, want 1/0/0", underflow, sample_stb, fifo_level);
        end
        enable = 1'b0;
        clear_flags();
    endtask

    task automatic test_full_pushpop();
        logic [15:0] exp_q [4] = '{16'h0A02, 16'h0A03, 16'h0A04, 16'h0BBB};
        rate_div = 16'd0;
        enable   = 1'b0;
        wr_sample(16'h0A01);
        wr_sample(16'h0A02);
        wr_sample(16'h0A03);
        wr_sample(16'h0A04);
        wr_byte(8'hBB);
        byte_in = 8'h0B;
        byte_we = 1'b1;
        enable  = 1'b1;
        step();
        byte_we = 1'b0;
        tests_run++;
        if (sample_stb !== 1'b1 || sample_out !== 16'h0A01 || fifo_level !== 3'd4 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_pushpop: stb=%b sample=%h level=%0d ovf=%b, want 1/0a01/4/0",
                     sample_stb, sample_out, fifo_level, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (sample_stb !== 1'b1 || sample_out !== exp_q[k]) begin
                fails++;
                $display("FAIL full_order: pop %0d stb=%b sample=%h, want 1/%h", k, sample_stb, sample_out, exp_q[k]);
            end
        end
        enable = 1'b0;
        step();
        tests_run++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_flags: unf=%b ovf=%b, want 0/0", underflow, overflow);
        end
    endtask

    task automatic test_byte_sync();
        enable = 1'b0;
        wr_byte(8'hAA);
        byte_sync = 1'b1;
        wr_byte(8'h11);
        byte_sync = 1'b0;
        tests_run++;
        if (fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL sync_low: level=%0d, want 0", fifo_level);
        end
        wr_byte(8'h22);
        tests_run++;
        if (fifo_level !== 3'd1) begin
            fails++;
            $display("FAIL sync_push: level=%0d, want 1", fifo_level);
        end
        rate_div = 16'd0;
        enable   = 1'b1;
        step();
        enable   = 1'b0;
        tests_run++;
        if (sample_stb !== 1'b1 || sample_out !== 16'h2211) begin
            fails++;
            $display("FAIL sync_value: stb=%b sample=%h, want 1/2211", sample_stb, sample_out);
        end
        step();
    endtask

    task automatic test_underflow_clr();
        logic [15:0] exp_s;
        logic        exp_stb;
`ifdef DS_SCHED_MUTE_ON_UNDERFLOW_EN
        exp_s   = 16'h8000;
        exp_stb = 1'b1;
`else
        exp_s   = 16'h2211;
        exp_stb = 1'b0;
`endif
        clear_flags();
        tests_run++;
        if (underflow !== 1'b0) begin
            fails++;
            $display("FAIL unf_idle: unf=%b, want 0", underflow);
        end
        rate_div = 16'd0;
        enable   = 1'b1;
        step();
        tests_run++;
        if (underflow !== 1'b1 || sample_stb !== exp_stb || sample_out !== exp_s) begin
            fails++;
            $display("FAIL unf_tick: unf=%b stb=%b sample=%h, want 1/%b/%h",
                     underflow, sample_stb, sample_out, exp_stb, exp_s);
        end
        clr_flags = 1'b1;
        step();
        tests_run++;
        if (underflow !== 1'b1) begin
            fails++;
            $display("FAIL unf_set_wins: unf=%b, want 1", underflow);
        end
        enable = 1'b0;
        step();
        clr_flags = 1'b0;
        tests_run++;
        if (underflow !== 1'b0) begin
            fails++;
            $display("FAIL unf_clear: unf=%b, want 0", underflow);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        wr_sample(16'h0101);
        wr_sample(16'h0202);
        wr_sample(16'h0303);
        wr_byte(8'h99);
        tests_run++;
        if (fifo_level !== 3'd3) begin
            fails++;
            $display("FAIL rstmid_pre: level=%0d, want 3", fifo_level);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (fifo_level !== 3'd0 || sample_out !== 16'h0000 || sample_stb !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: level=%0d sample=%h stb=%b unf=%b, want 0/0000/0/0",
                     fifo_level, sample_out, sample_stb, underflow);
        end
        step();
        rst_n = 1'b1;
        wr_byte(8'h44);
        tests_run++;
        if (fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL rstmid_phase: level=%0d, want 0", fifo_level);
        end
        wr_byte(8'h33);
        rate_div = 16'd0;
        enable   = 1'b1;
        step();
        enable   = 1'b0;
        tests_run++;
        if (sample_stb !== 1'b1 || sample_out !== 16'h3344) begin
            fails++;
            $display("FAIL rstmid_fresh: stb=%b sample=%h, want 1/3344", sample_stb, sample_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rate();
        test_overflow();
        test_full_pushpop();
        test_byte_sync();
        test_underflow_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ds_sample_scheduler.md
Name: ds_sample_scheduler

Overview:
Feeds 16-bit samples to the delta-sigma modulator's target register at a programmable sample rate.
- Host side: byte stream on the TT pins, assembled into 16-bit samples and buffered in a small FIFO.
- Modulator side: a rate divider pops one sample per period, drives sample_out and pulses sample_stb.
- Sits between the pin/register front end and the modulator, so audio-rate streaming does not depend on host timing.

Parameters:
- SAMPLE_BITS, 16, width of one sample and of sample_out.
- DIV_BITS, 16, width of rate_div and of the internal rate counter.
- DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run rate divider and pops; 0 = paused.
- byte_in  in  8  host data byte.
- byte_we  in  1  byte_in valid this cycle.
- byte_sync  in  1  force next byte to be treated as low byte.
- rate_div  in  DIV_BITS  sample period minus 1, in clk cycles.
- clr_flags  in  1  clear sticky flags.
- sample_out  out  SAMPLE_BITS  current sample to modulator.
- sample_stb  out  1  one-cycle pulse, sample_out just updated.
- fifo_level  out  DEPTH_LOG2+1  entries stored.
- fifo_full  out  1  level == 2^DEPTH_LOG2.
- underflow  out  1  sticky: tick with empty FIFO.
- overflow  out  1  sticky: completed sample dropped because FIFO full.

Behaviour:
- Reset (async, rst_n=0):
  - sample_out=0, sample_stb=0, fifo_level=0, flags=0.
  - byte phase = low, counter = 0, FIFO pointers = 0.
  - Reset mid-operation discards buffered samples and any half-assembled sample.
- Byte assembly:
  - Phase bit toggles on each byte_we.
  - Low phase: byte stored in a holding register.
  - High phase: {byte_in, hold} forms the sample and a push is requested.
  - byte_sync=1 forces phase to low; if byte_we is also high that cycle, the byte is taken as the low byte.
- Rate counter (enable=1): counts down from rate_div; tick when counter==0, then reload rate_div.
  - rate_div=0 gives a tick every cycle.
  - rate_div changes take effect at the next reload.
- enable=0:
  - Counter is loaded with rate_div and no ticks occur.
  - Byte pushes continue.
  - On the rising edge of enable, the first tick occurs rate_div+1 cycles later.
- Pop on tick:
  - FIFO non-empty: head is registered into sample_out; sample_stb=1 the next cycle.
  - FIFO empty: underflow set, sample_out held, no strobe.
- Push rules:
  - Accepted if level after this cycle's pop < depth.
  - Push and pop in the same cycle when full: push is accepted, level unchanged.
  - Push and pop when empty: underflow, push stored; no bypass.
  - Push rejected: sample dropped, overflow set.
- Latency:
  - High-byte write in cycle N: fifo_level reflects it in N+1.
  - Tick in cycle N: sample_out/sample_stb valid in N+1.
- Flags: clr_flags clears both flags. If a set and clr_flags occur in the same cycle, set wins.
- FIFO pointers wrap modulo depth; level is kept with one extra bit, so full and empty are distinct.

Optional Feature:
DS_SCHED_MUTE_ON_UNDERFLOW_EN.
- Defined: a tick with empty FIFO loads sample_out = 16'h8000 (midscale, offset binary) and pulses sample_stb; underflow is still set.
- Undefined: sample_out is held on underflow and there is no strobe.

Decomposition:
- Package ds_sched_pkg holds:
  - SAMPLE_BITS, DIV_BITS, DEPTH_LOG2 defaults.
  - typedef sample_t (logic [SAMPLE_BITS-1:0]).
  - localparam MIDSCALE = 16'h8000.
- Sub-module ds_sample_fifo: synchronous FIFO with push/pop/level/full/empty and the simultaneous push/pop-when-full rule.
- Byte assembly, rate counter and flags stay in the top module.

Test Plan:
- Reset, then rate_div=3, enable=1; write bytes 34,12 then 78,56 → sample_stb pulses 4 cycles apart, sample_out=0x1234 then 0x5678; underflow rises on the third tick.
- enable=0; write 5 samples 0x0001..0x0005 → fifo_level=4, fifo_full=1, overflow=1; enable=1 pops 0x0001..0x0004 in order.
- Fill FIFO (level 4) with rate_div=0; complete a sample on the same cycle as a tick → level stays 4, overflow stays 0, new sample is popped last.
- byte_we 0xAA, then byte_sync with byte_we 0x11, then 0x22 → stored sample 0x2211; 0xAA discarded.
- FIFO empty, tick → underflow=1; clr_flags on a cycle with another underflow tick → underflow remains 1. With DS_SCHED_MUTE_ON_UNDERFLOW_EN: sample_out=0x8000 with strobe.
- Assert rst_n=0 asynchronously mid-stream with level 3 and the low byte pending → outputs zero immediately; after release, the next two bytes form a fresh sample.
